// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: ID-stage operand forwarding selects and load-use stall control with shadow EX/MEM destination tracking
module fwd_hazard_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_wreg,
  input  logic              id_m2reg,
  input  logic [REG_AW-1:0] id_rn,
  input  logic              id_flush,
  output logic [1:0]        fwda,
  output logic [1:0]        fwdb,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_cnt
);
  logic              r_ex_wreg, r_ex_m2reg, r_mem_wreg, r_mem_m2reg;
  logic [REG_AW-1:0] r_ex_rn, r_mem_rn;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              w_ex_a, w_ex_b, w_mem_a, w_mem_b, w_stall, w_bubble;

  // Register 0 is hard-wired, so it never matches a producer.
  assign w_ex_a   = r_ex_wreg  && r_ex_rn  == id_rs && id_rs != '0 && id_use_rs;
  assign w_ex_b   = r_ex_wreg  && r_ex_rn  == id_rt && id_rt != '0 && id_use_rt;
  assign w_mem_a  = r_mem_wreg && r_mem_rn == id_rs && id_rs != '0 && id_use_rs;
  assign w_mem_b  = r_mem_wreg && r_mem_rn == id_rt && id_rt != '0 && id_use_rt;
  assign w_stall  = !id_flush && r_ex_m2reg && (w_ex_a || w_ex_b);
  assign w_bubble = w_stall || id_flush;

  // Youngest producer wins; a load still in EX yields 00 since that operand is re-read after the stall.
  always_comb begin
    fwda = w_ex_a ? (r_ex_m2reg ? 2'b00 : 2'b01) : w_mem_a ? {1'b1, r_mem_m2reg} : 2'b00;
    fwdb = w_ex_b ? (r_ex_m2reg ? 2'b00 : 2'b01) : w_mem_b ? {1'b1, r_mem_m2reg} : 2'b00;
  end

  assign stall     = w_stall;
  assign stall_cnt = r_stall_cnt;

  // Shadow EX/MEM destination pipeline plus saturating stall counter.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_ex_wreg   <= 1'b0;
      r_ex_m2reg  <= 1'b0;
      r_ex_rn     <= '0;
      r_mem_wreg  <= 1'b0;
      r_mem_m2reg <= 1'b0;
      r_mem_rn    <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_mem_wreg  <= r_ex_wreg;
      r_mem_m2reg <= r_ex_m2reg;
      r_mem_rn    <= r_ex_rn;
      r_ex_wreg   <= w_bubble ? 1'b0 : id_wreg;
      r_ex_m2reg  <= w_bubble ? 1'b0 : id_m2reg;
      r_ex_rn     <= w_bubble ? '0 : id_rn;
      if (w_stall && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end
endmodule
